// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/gnt/rvalid port with one
// outstanding access, and presents a registered {pc, inst, valid} triple to decode.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid
);

    // state  | meaning
    // S_REQ  | idle or requesting; fetch of pc_q may be issued
    // S_WAIT | one access outstanding, response belongs to pc_out_q
    // S_DROP | outstanding access became stale through a flush; discard it
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_inst_q, buf_inst_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic        id_valid_q, id_valid_d;
    logic        resp;

    assign imem_req  = (state_q == S_REQ) && !buf_valid_q && !flush && !rst;
    assign imem_addr = pc_q;
    assign id_pc     = id_pc_q;
    assign id_inst   = id_inst_q;
    assign id_valid  = id_valid_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pc_out_d    = pc_out_q;
        buf_valid_d = buf_valid_q;
        buf_pc_d    = buf_pc_q;
        buf_inst_d  = buf_inst_q;
        id_pc_d     = id_pc_q;
        id_inst_d   = id_inst_q;
        id_valid_d  = id_valid_q;
        resp        = (state_q == S_WAIT) && imem_rvalid && !flush;

        if (flush) begin
            pc_d        = redirect_pc;
            id_valid_d  = 1'b0;
            id_inst_d   = NOP_INST;
            buf_valid_d = 1'b0;
            case (state_q)
                S_WAIT:  state_d = imem_rvalid ? S_REQ : S_DROP;
                S_DROP:  state_d = imem_rvalid ? S_REQ : S_DROP;
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (imem_req && imem_gnt) begin
                        pc_out_d = pc_q;
                        pc_d     = pc_q + 32'd4;
                        state_d  = S_WAIT;
                    end
                end
                S_WAIT:  if (imem_rvalid) state_d = S_REQ;
                S_DROP:  if (imem_rvalid) state_d = S_REQ;
                default: state_d = S_REQ;
            endcase

            // A response that decode cannot take this cycle parks in the buffer
            if (!stall) begin
                if (buf_valid_q) begin
                    id_pc_d     = buf_pc_q;
                    id_inst_d   = buf_inst_q;
                    id_valid_d  = 1'b1;
                    buf_valid_d = 1'b0;
                end else if (resp) begin
                    id_pc_d    = pc_out_q;
                    id_inst_d  = imem_rdata;
                    id_valid_d = 1'b1;
                end else begin
                    id_valid_d = 1'b0;
                    id_inst_d  = NOP_INST;
                end
            end else if (resp) begin
                buf_valid_d = 1'b1;
                buf_pc_d    = pc_out_q;
                buf_inst_d  = imem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            pc_out_q    <= 32'd0;
            buf_valid_q <= 1'b0;
            buf_pc_q    <= 32'd0;
            buf_inst_q  <= 32'd0;
            id_pc_q     <= 32'd0;
            id_inst_q   <= NOP_INST;
            id_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pc_out_q    <= pc_out_d;
            buf_valid_q <= buf_valid_d;
            buf_pc_q    <= buf_pc_d;
            buf_inst_q  <= buf_inst_d;
            id_pc_q     <= id_pc_d;
            id_inst_q   <= id_inst_d;
            id_valid_q  <= id_valid_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios followed by randomized stall/grant/latency/flush
// traffic, checked against an in-order fetch-stream reference and a memory model.
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall, flush, imem_gnt, imem_rvalid;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, id_valid;
    logic [31:0] imem_addr, id_pc, id_inst;

    if_stage #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int n_cons   = 0;

    logic [31:0] key = 32'd0;
    logic [31:0] fetch_exp, cons_exp;
    logic        mem_busy = 1'b0;
    logic [31:0] mem_addr;
    int          mem_lat = 0;
    int          lat_min = 0, lat_max = 0;
    logic        s_req;
    logic [31:0] s_addr;
    logic [31:0] p_pc, p_inst;
    logic        p_valid, c_rst, c_stall, c_flush, c_gnt, c_rvalid;
    logic [31:0] c_redir;

    function automatic logic [31:0] f(input logic [31:0] a);
        return a ^ key;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive the memory response, sample before the edge, update the reference after it.
    task automatic step();
        if (mem_busy && mem_lat == 0 && !rst) begin
            imem_rvalid = 1'b1;
            imem_rdata  = f(mem_addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        @(negedge clk);
        s_req  = imem_req;
        s_addr = imem_addr;
        if (rst || flush) check("req_blocked", {31'd0, s_req}, 32'd0);
        if (s_req && imem_gnt) check("fetch_addr", s_addr, fetch_exp);
        p_pc = id_pc; p_inst = id_inst; p_valid = id_valid;
        c_rst = rst; c_stall = stall; c_flush = flush; c_gnt = imem_gnt;
        c_rvalid = imem_rvalid; c_redir = redirect_pc;
        @(posedge clk);
        #1;
        if (c_rst) begin
            fetch_exp = RST_PC;
            cons_exp  = RST_PC;
            mem_busy  = 1'b0;
            check("rst_id_valid", {31'd0, id_valid}, 32'd0);
            check("rst_id_pc", id_pc, 32'd0);
        end else begin
            if (p_valid && !c_stall && !c_flush) begin
                check("cons_pc", p_pc, cons_exp);
                check("cons_inst", p_inst, f(p_pc));
                cons_exp = cons_exp + 32'd4;
                n_cons++;
            end
            if (c_flush) begin
                cons_exp  = c_redir;
                fetch_exp = c_redir;
                check("flush_id_valid", {31'd0, id_valid}, 32'd0);
            end else if (s_req && c_gnt) begin
                fetch_exp = fetch_exp + 32'd4;
            end
            if (c_stall && !c_flush) begin
                check("hold_valid", {31'd0, id_valid}, {31'd0, p_valid});
                check("hold_pc", id_pc, p_pc);
                check("hold_inst", id_inst, p_inst);
            end
            if (c_rvalid) mem_busy = 1'b0;
            else if (mem_busy && mem_lat > 0) mem_lat--;
            if (s_req && c_gnt) begin
                mem_busy = 1'b1;
                mem_addr = s_addr;
                mem_lat  = $urandom_range(lat_max, lat_min);
            end
        end
        if (!id_valid) check("gap_nop", id_inst, NOP);
    endtask

    initial begin
        logic [31:0] held, a0;
        int          k;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_pc = 32'd0;
        imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        fetch_exp = RST_PC; cons_exp = RST_PC;

        step(); step();
        check("rst_inst", id_inst, NOP);

        // Free run with a single-cycle memory: valid every other cycle, wrapping through 0
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 1) check("first_req", {31'd0, s_req}, 32'd1);
            check("free_valid", {31'd0, id_valid}, {31'd0, (i % 2 == 0)});
            if (i % 2 == 0) check("free_pc", id_pc, RST_PC + 32'(4 * (i / 2 - 1)));
        end

        // Stall for 6 cycles while the next fetch completes into the buffer
        held = id_pc;
        stall = 1'b1;
        repeat (6) step();
        check("stall_no_req", {31'd0, s_req}, 32'd0);
        check("stall_hold_pc", id_pc, held);
        stall = 1'b0;
        lat_min = 2; lat_max = 2;
        step();
        check("unstall_valid", {31'd0, id_valid}, 32'd1);
        check("unstall_pc", id_pc, held + 32'd4);
        step();
        check("resume_req", {31'd0, s_req}, 32'd1);
        check("resume_addr", s_addr, held + 32'd8);

        // Flush with the access still outstanding; the stale response must be dropped
        flush = 1'b1; redirect_pc = 32'h100;
        step();
        flush = 1'b0;
        step();
        check("drop_no_req", {31'd0, s_req}, 32'd0);
        k = 0;
        while (!id_valid && k < 12) begin step(); k++; end
        check("redir_valid", {31'd0, id_valid}, 32'd1);
        check("redir_pc", id_pc, 32'h100);

        // Flush and stall together while the buffer holds an entry
        lat_min = 0; lat_max = 0;
        stall = 1'b1;
        repeat (4) step();
        check("buf_full_no_req", {31'd0, s_req}, 32'd0);
        flush = 1'b1; redirect_pc = 32'h200;
        step();
        check("fs_valid", {31'd0, id_valid}, 32'd0);
        flush = 1'b0; stall = 1'b0;
        k = 0;
        while (!id_valid && k < 12) begin step(); k++; end
        check("fs_pc", id_pc, 32'h200);

        // Grant withheld: request and address must stay put
        imem_gnt = 1'b0;
        k = 0;
        step();
        while (!s_req && k < 6) begin step(); k++; end
        a0 = s_addr;
        for (int i = 0; i < 3; i++) begin
            step();
            check("nogrant_req", {31'd0, s_req}, 32'd1);
            check("nogrant_addr", s_addr, a0);
        end
        imem_gnt = 1'b1;
        lat_min = 3; lat_max = 3;
        step();
        check("grant_addr", s_addr, a0);

        // Reset pulse while an access is pending
        rst = 1'b1;
        step();
        check("rst_wait_inst", id_inst, NOP);
        rst = 1'b0;
        step();
        check("rst_wait_req", {31'd0, s_req}, 32'd1);
        check("rst_wait_addr", s_addr, RST_PC);

        // Randomized traffic
        key = 32'h5A5A_F00D;
        lat_min = 0; lat_max = 3;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cons = 0;
        for (int i = 0; i < 2000; i++) begin
            stall       = ($urandom_range(3, 0) == 0);
            imem_gnt    = ($urandom_range(3, 0) != 0);
            flush       = ($urandom_range(31, 0) == 0);
            redirect_pc = $urandom & 32'hFFFF_FFFC;
            rst         = ($urandom_range(499, 0) == 0);
            step();
        end
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        check("progress", {31'd0, (n_cons >= 100)}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
